multicycle_ctrl: RTL and testbench

//   Multi-cycle control FSM for the RV64I core. Sequences fetch/decode/execute/memory/writeback over a shared datapath.

---
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle fetch/decode/execute/memory/writeback sequencer
//               for an RV64I core sharing one datapath and one memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
   parameter int NONE_STATE_W = 3
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [31:0]             inst,
   input  logic                    branch_taken,
   input  logic                    mem_ready,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic                    mem_is_fetch,
   output logic                    ir_write,
   output logic                    pc_write,
   output logic [1:0]              pc_src,
   output logic [2:0]              immgen_op,
   output logic                    alu_src_a,
   output logic                    alu_src_b,
   output logic                    reg_write,
   output logic [1:0]              wb_sel,
   output logic                    csr_we,
   output logic                    illegal,
   output logic [NONE_STATE_W-1:0] state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      CL_OP     = 4'd0,
      CL_OPIMM  = 4'd1,
      CL_LOAD   = 4'd2,
      CL_STORE  = 4'd3,
      CL_BRANCH = 4'd4,
      CL_LUI    = 4'd5,
      CL_AUIPC  = 4'd6,
      CL_JAL    = 4'd7,
      CL_JALR   = 4'd8,
      CL_CSR    = 4'd9,
      CL_ILL    = 4'd10
   } cls_t;

   localparam logic [6:0] c_opc_load     = 7'b0000011;
   localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
   localparam logic [6:0] c_opc_op_imm32 = 7'b0011011;
   localparam logic [6:0] c_opc_jalr     = 7'b1100111;
   localparam logic [6:0] c_opc_store    = 7'b0100011;
   localparam logic [6:0] c_opc_branch   = 7'b1100011;
   localparam logic [6:0] c_opc_lui      = 7'b0110111;
   localparam logic [6:0] c_opc_auipc    = 7'b0010111;
   localparam logic [6:0] c_opc_jal      = 7'b1101111;
   localparam logic [6:0] c_opc_system   = 7'b1110011;
   localparam logic [6:0] c_opc_op       = 7'b0110011;
   localparam logic [6:0] c_opc_op32     = 7'b0111011;

   state_t r_state;
   cls_t   r_cls;
   cls_t   w_dec_cls;
   cls_t   w_cls;
   state_t w_next;
   logic   w_unused_inst;

   function automatic logic [2:0] imm_of(input cls_t c);
      case (c)
         CL_OPIMM, CL_LOAD, CL_JALR: imm_of = 3'd1;
         CL_STORE:                   imm_of = 3'd2;
         CL_BRANCH:                  imm_of = 3'd3;
         CL_LUI, CL_AUIPC:           imm_of = 3'd4;
         CL_JAL:                     imm_of = 3'd5;
         CL_CSR:                     imm_of = 3'd6;
         default:                    imm_of = 3'd0;
      endcase
   endfunction

   function automatic logic [1:0] wb_of(input cls_t c);
      case (c)
         CL_LOAD:         wb_of = 2'd1;
         CL_JAL, CL_JALR: wb_of = 2'd2;
         CL_LUI:          wb_of = 2'd3;
         default:         wb_of = 2'd0;
      endcase
   endfunction

   always_comb begin
      w_dec_cls = CL_ILL;
      case (inst[6:0])
         c_opc_load:                    w_dec_cls = CL_LOAD;
         c_opc_op_imm, c_opc_op_imm32:  w_dec_cls = CL_OPIMM;
         c_opc_jalr:                    w_dec_cls = CL_JALR;
         c_opc_store:                   w_dec_cls = CL_STORE;
         c_opc_branch:                  w_dec_cls = CL_BRANCH;
         c_opc_lui:                     w_dec_cls = CL_LUI;
         c_opc_auipc:                   w_dec_cls = CL_AUIPC;
         c_opc_jal:                     w_dec_cls = CL_JAL;
         c_opc_system:                  w_dec_cls = (inst[14:12] != 3'd0) ? CL_CSR : CL_ILL;
         c_opc_op, c_opc_op32:          w_dec_cls = CL_OP;
         default:                       w_dec_cls = CL_ILL;
      endcase
   end

   // The class is only trusted from inst during DECODE; afterwards the latched copy is used.
   assign w_cls         = (r_state == S_DECODE) ? w_dec_cls : r_cls;
   assign w_unused_inst = ^{inst[31:15], inst[11:7]};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: w_next = (w_dec_cls == CL_ILL) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            if (w_cls == CL_LOAD || w_cls == CL_STORE) w_next = S_MEM;
            else if (w_cls == CL_BRANCH)               w_next = S_FETCH;
            else                                       w_next = S_WB;
         end
         S_MEM: begin
            if (mem_ready) w_next = (w_cls == CL_LOAD) ? S_WB : S_FETCH;
         end
         S_WB:     w_next = S_FETCH;
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_IDLE;
      endcase
   end

   // Moore outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_cls        <= CL_OP;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_is_fetch <= 1'b0;
         alu_src_a    <= 1'b0;
         alu_src_b    <= 1'b0;
         reg_write    <= 1'b0;
         wb_sel       <= 2'd0;
         csr_we       <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         r_state      <= w_next;
         if (r_state == S_DECODE) r_cls <= w_dec_cls;
         mem_req      <= (w_next == S_FETCH) || (w_next == S_MEM);
         mem_is_fetch <= (w_next == S_FETCH);
         mem_we       <= (w_next == S_MEM) && (w_cls == CL_STORE);
         alu_src_a    <= (w_next == S_EXEC) && (w_cls == CL_AUIPC);
         alu_src_b    <= (w_next == S_EXEC) &&
                         (w_cls inside {CL_OPIMM, CL_LOAD, CL_STORE, CL_JALR, CL_LUI, CL_AUIPC});
         reg_write    <= (w_next == S_WB);
         wb_sel       <= (w_next == S_WB) ? wb_of(w_cls) : 2'd0;
         csr_we       <= (w_next == S_WB) && (w_cls == CL_CSR);
         illegal      <= (w_next == S_TRAP);
      end
   end

   // Strobes qualified by the same-cycle handshake or branch compare.
   always_comb begin
      ir_write  = (r_state == S_FETCH) && mem_ready;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      immgen_op = 3'd0;
      if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) immgen_op = imm_of(w_cls);
      case (r_state)
         S_EXEC: begin
            if (w_cls == CL_BRANCH) begin
               pc_write = 1'b1;
               pc_src   = {1'b0, branch_taken};
            end
         end
         S_MEM: begin
            pc_write = mem_ready && (w_cls == CL_STORE);
         end
         S_WB: begin
            pc_write = 1'b1;
            if (w_cls == CL_JAL)       pc_src = 2'd1;
            else if (w_cls == CL_JALR) pc_src = 2'd2;
         end
         default: ;
      endcase
   end

   assign state = NONE_STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl: vector table,
//               directed corner sequences and a randomized reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] inst;
   logic        branch_taken;
   logic        mem_ready;
   logic        mem_req, mem_we, mem_is_fetch, ir_write, pc_write;
   logic [1:0]  pc_src;
   logic [2:0]  immgen_op;
   logic        alu_src_a, alu_src_b, reg_write;
   logic [1:0]  wb_sel;
   logic        csr_we, illegal;
   logic [2:0]  state;

   always #5 clk = ~clk;

   multicycle_ctrl #(.NONE_STATE_W(3)) dut (
      .clk(clk), .rstn(rstn), .inst(inst), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_is_fetch(mem_is_fetch), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .immgen_op(immgen_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel),
      .csr_we(csr_we), .illegal(illegal), .state(state)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // {state, req, we, fetch, ir_write, pc_write, pc_src, immgen, a, b, reg_write, wb_sel, csr_we, illegal}
   function automatic logic [19:0] pack(input logic [2:0] st, input logic req, input logic we,
                                        input logic fe, input logic irw, input logic pcw,
                                        input logic [1:0] pcs, input logic [2:0] imm,
                                        input logic a, input logic b, input logic rw,
                                        input logic [1:0] wbs, input logic csr, input logic ill);
      return {st, req, we, fe, irw, pcw, pcs, imm, a, b, rw, wbs, csr, ill};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {state, mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src, immgen_op,
              alu_src_a, alu_src_b, reg_write, wb_sel, csr_we, illegal};
   endfunction

   // ---------------- reference model: per-opcode attributes ----------------
   typedef struct packed {
      logic       legal;
      logic [2:0] imm;
      logic       is_mem;
      logic       store;
      logic       branch;
      logic       a;
      logic       b;
      logic [1:0] wbs;
      logic [1:0] wbpc;
      logic       csr;
   } attr_t;

   function automatic attr_t attr_of(input logic [31:0] i);
      attr_t t = '0;
      t.legal = 1'b1;
      case (i[6:0])
         7'h03:        begin t.imm = 3'd1; t.is_mem = 1'b1; t.b = 1'b1; t.wbs = 2'd1; end
         7'h13, 7'h1B: begin t.imm = 3'd1; t.b = 1'b1; end
         7'h67:        begin t.imm = 3'd1; t.b = 1'b1; t.wbs = 2'd2; t.wbpc = 2'd2; end
         7'h23:        begin t.imm = 3'd2; t.is_mem = 1'b1; t.store = 1'b1; t.b = 1'b1; end
         7'h63:        begin t.imm = 3'd3; t.branch = 1'b1; end
         7'h37:        begin t.imm = 3'd4; t.b = 1'b1; t.wbs = 2'd3; end
         7'h17:        begin t.imm = 3'd4; t.a = 1'b1; t.b = 1'b1; end
         7'h6F:        begin t.imm = 3'd5; t.wbs = 2'd2; t.wbpc = 2'd1; end
         7'h73:        if (i[14:12] != 3'd0) begin t.imm = 3'd6; t.csr = 1'b1; end
                       else t.legal = 1'b0;
         7'h33, 7'h3B: ;
         default:      t.legal = 1'b0;
      endcase
      return t;
   endfunction

   typedef struct {
      logic [31:0] ins;
      logic        rdy;
      logic        tk;
      logic [19:0] exp;
   } vec_t;

   vec_t q[$];

   // Builds the expected cycle-by-cycle trace for one instruction starting in FETCH.
   function automatic void build(input logic [31:0] i, input int fw, input int mw, input logic tk);
      attr_t t = attr_of(i);
      logic [2:0] imm = t.legal ? t.imm : 3'd0;
      for (int k = 0; k <= fw; k++) begin
         logic last = (k == fw);
         q.push_back('{$urandom, last, 1'($urandom),
                       pack(3'd1, 1'b1, 1'b0, 1'b1, last, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
      end
      q.push_back('{i, 1'($urandom), 1'($urandom),
                    pack(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, imm, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
      if (!t.legal) begin
         for (int k = 0; k < 4; k++)
            q.push_back('{i, 1'($urandom), 1'($urandom),
                          pack(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1)});
         return;
      end
      q.push_back('{i, 1'($urandom), tk,
                    pack(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, t.branch, t.branch ? {1'b0, tk} : 2'd0, imm,
                         t.a, t.b, 1'b0, 2'd0, 1'b0, 1'b0)});
      if (t.is_mem) begin
         for (int k = 0; k <= mw; k++) begin
            logic last = (k == mw);
            q.push_back('{i, last, 1'($urandom),
                          pack(3'd4, 1'b1, t.store, 1'b0, 1'b0, last && t.store, 2'd0, imm,
                               1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
         end
      end
      if (!t.branch && !t.store)
         q.push_back('{i, 1'($urandom), 1'($urandom),
                       pack(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t.wbpc, imm, 1'b0, 1'b0, 1'b1,
                            t.wbs, t.csr, 1'b0)});
   endfunction

   task automatic run_q(input string name);
      while (q.size() > 0) begin
         vec_t v = q.pop_front();
         inst = v.ins; mem_ready = v.rdy; branch_taken = v.tk;
         #1;
         chk(name, 32'(dut_vec()), 32'(v.exp));
         @(negedge clk); #1;
      end
   endtask

   // Leaves the bench sampling the first FETCH cycle after reset.
   task automatic do_reset();
      mem_ready = 1'b0;
      rstn = 1'b0;
      #1;
      chk("reset_outputs", 32'(dut_vec()), 32'h0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("idle_after_reset", 32'(dut_vec()), 32'h0);
      @(negedge clk); #1;
   endtask

   task automatic measure(input logic [31:0] i, input logic tk, output int cyc,
                          output logic [2:0] imm, output logic a, output logic b,
                          output int nrw, output logic [1:0] wbs, output int npcw,
                          output logic [1:0] pcs, output int ncsr);
      inst = i; branch_taken = tk; mem_ready = 1'b1;
      cyc = 0; imm = 3'd0; a = 1'b0; b = 1'b0; nrw = 0; wbs = 2'd0; npcw = 0; pcs = 2'd0; ncsr = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (state == 3'd3) begin imm = immgen_op; a = alu_src_a; b = alu_src_b; end
         if (pc_write)  begin npcw++; pcs = pc_src; end
         if (reg_write) begin nrw++; wbs = wb_sel; end
         if (csr_we) ncsr++;
         @(negedge clk); #1;
         cyc++;
         if (state == 3'd1) break;
      end
   endtask

   typedef struct {
      logic [31:0] ins;
      logic        tk;
      int          lat;
      logic [2:0]  imm;
      logic        a;
      logic        b;
      int          nrw;
      logic [1:0]  wbs;
      logic [1:0]  pcs;
      int          ncsr;
   } tv_t;

   tv_t tbl[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, nrw, npcw, ncsr;
      logic [2:0] imm;
      logic a, b;
      logic [1:0] wbs, pcs;
      logic [6:0] opcs[11];
      logic [31:0] ri;

      tbl[0]  = '{32'h00500093, 1'b0, 5, 3'd1, 1'b0, 1'b1, 1, 2'd0, 2'd0, 0}; // addi
      tbl[1]  = '{32'h008000EF, 1'b0, 5, 3'd5, 1'b0, 1'b0, 1, 2'd2, 2'd1, 0}; // jal
      tbl[2]  = '{32'h00000463, 1'b1, 4, 3'd3, 1'b0, 1'b0, 0, 2'd0, 2'd1, 0}; // beq taken
      tbl[3]  = '{32'h00000463, 1'b0, 4, 3'd3, 1'b0, 1'b0, 0, 2'd0, 2'd0, 0}; // beq not taken
      tbl[4]  = '{32'h0000B103, 1'b0, 6, 3'd1, 1'b0, 1'b1, 1, 2'd1, 2'd0, 0}; // ld
      tbl[5]  = '{32'h00113423, 1'b0, 5, 3'd2, 1'b0, 1'b1, 0, 2'd0, 2'd0, 0}; // sd
      tbl[6]  = '{32'h123450B7, 1'b0, 5, 3'd4, 1'b0, 1'b1, 1, 2'd3, 2'd0, 0}; // lui
      tbl[7]  = '{32'h00001097, 1'b0, 5, 3'd4, 1'b1, 1'b1, 1, 2'd0, 2'd0, 0}; // auipc
      tbl[8]  = '{32'h000080E7, 1'b0, 5, 3'd1, 1'b0, 1'b1, 1, 2'd2, 2'd2, 0}; // jalr
      tbl[9]  = '{32'h002081B3, 1'b0, 5, 3'd0, 1'b0, 1'b0, 1, 2'd0, 2'd0, 0}; // add
      tbl[10] = '{32'h34011073, 1'b0, 5, 3'd6, 1'b0, 1'b0, 1, 2'd0, 2'd0, 1}; // csrrw
      tbl[11] = '{32'h0010809B, 1'b0, 5, 3'd1, 1'b0, 1'b1, 1, 2'd0, 2'd0, 0}; // addiw
      tbl[12] = '{32'h002081BB, 1'b0, 5, 3'd0, 1'b0, 1'b0, 1, 2'd0, 2'd0, 0}; // addw

      opcs = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};

      inst = 32'h0; branch_taken = 1'b0; mem_ready = 1'b0; rstn = 1'b1;
      #1;
      do_reset();

      // Reset asserted while a fetch is outstanding.
      mem_ready = 1'b0;
      #1;
      chk("fetch_req_pending", 32'({mem_req, mem_is_fetch, state}), 32'({1'b1, 1'b1, 3'd1}));
      rstn = 1'b0;
      #1;
      chk("reset_mid_fetch", 32'(dut_vec()), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("idle_after_mid_reset", 32'(dut_vec()), 32'h0);
      @(negedge clk); #1;
      chk("fetch_after_idle", 32'(dut_vec()),
          32'(pack(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0)));

      // Zero-wait vector table.
      foreach (tbl[n]) begin
         measure(tbl[n].ins, tbl[n].tk, cyc, imm, a, b, nrw, wbs, npcw, pcs, ncsr);
         chk($sformatf("tbl%0d_latency", n), 32'(cyc + 1), 32'(tbl[n].lat));
         chk($sformatf("tbl%0d_immgen", n), 32'(imm), 32'(tbl[n].imm));
         chk($sformatf("tbl%0d_alu_src_a", n), 32'(a), 32'(tbl[n].a));
         chk($sformatf("tbl%0d_alu_src_b", n), 32'(b), 32'(tbl[n].b));
         chk($sformatf("tbl%0d_reg_write_cnt", n), 32'(nrw), 32'(tbl[n].nrw));
         chk($sformatf("tbl%0d_wb_sel", n), 32'(wbs), 32'(tbl[n].wbs));
         chk($sformatf("tbl%0d_pc_write_cnt", n), 32'(npcw), 32'd1);
         chk($sformatf("tbl%0d_pc_src", n), 32'(pcs), 32'(tbl[n].pcs));
         chk($sformatf("tbl%0d_csr_we_cnt", n), 32'(ncsr), 32'(tbl[n].ncsr));
      end

      // Store with three wait states, then ADDI with zero-wait memory.
      build(32'h00113423, 0, 3, 1'b0);
      run_q("sd_wait3");
      build(32'h00500093, 0, 0, 1'b0);
      run_q("addi_zero_wait");
      build(32'h00000463, 2, 0, 1'b1);
      run_q("beq_taken_fetch_wait");

      // Randomized legal instruction stream.
      for (int n = 0; n < 120; n++) begin
         ri = $urandom;
         ri[6:0] = opcs[$urandom_range(0, 10)];
         if (ri[6:0] == 7'h73 && ri[14:12] == 3'd0) ri[14:12] = 3'($urandom_range(1, 7));
         build(ri, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
         run_q($sformatf("rand%0d_%h", n, ri));
      end

      // Illegal encodings trap and stay trapped until reset.
      build(32'h00000073, 1, 0, 1'b0);
      run_q("ecall_trap");
      do_reset();
      build(32'h0000007F, 0, 0, 1'b0);
      run_q("opcode7f_trap");
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
